// File: rtl/data_mem_responder.sv
module data_mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 12,
  parameter int LATENCY       = 2,
  parameter     MEM_INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  stateT state;
  stateT stateNext;

  logic [3:0]            count;
  logic [3:0]            countNext;
  logic                  captureEn;
  logic                  commit;
  logic                  respTaken;

  logic                  capWrite;
  logic [2:0]            capFunct3;
  logic [ADDR_WIDTH-1:0] capAddr;
  logic [DATA_WIDTH-1:0] capWdata;

  logic                  accessWrite;
  logic [2:0]            accessFunct3;
  logic [ADDR_WIDTH-1:0] accessAddr;
  logic [DATA_WIDTH-1:0] accessWdata;

  logic [ADDR_WIDTH-3:0] wordIdx;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] rdWord;
  logic [7:0]            byteVal;
  logic [15:0]           halfVal;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] newWord;
  logic                  accessErr;

  logic [DATA_WIDTH-1:0] respRdata;
  logic                  respErr;

  logic                  unusedAddrBits;

  logic [DATA_WIDTH-1:0] memArray [WORDS];

  assign unusedAddrBits = ^req_addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = respRdata;
  assign resp_err   = respErr;

  // With LATENCY = 1 the commit happens on the accept edge, so the access
  // uses the live request fields in IDLE and the captured ones otherwise.
  always_comb begin
    if (state == IDLE) begin
      accessWrite  = req_write;
      accessFunct3 = req_funct3;
      accessAddr   = req_addr[ADDR_WIDTH-1:0];
      accessWdata  = req_wdata;
    end else begin
      accessWrite  = capWrite;
      accessFunct3 = capFunct3;
      accessAddr   = capAddr;
      accessWdata  = capWdata;
    end
  end

  assign wordIdx = accessAddr[ADDR_WIDTH-1:2];
  assign lane    = accessAddr[1:0];
  assign rdWord  = memArray[wordIdx];

  always_comb begin
    accessErr = 1'b0;
    loadData  = '0;
    case (lane)
      2'd0:    byteVal = rdWord[7:0];
      2'd1:    byteVal = rdWord[15:8];
      2'd2:    byteVal = rdWord[23:16];
      default: byteVal = rdWord[31:24];
    endcase
    halfVal = lane[1] ? rdWord[31:16] : rdWord[15:0];
    if (accessWrite) begin
      case (accessFunct3)
        3'b000:  accessErr = 1'b0;
        3'b001:  accessErr = lane[0];
        3'b010:  accessErr = (lane != 2'd0);
        default: accessErr = 1'b1;
      endcase
    end else begin
      case (accessFunct3)
        3'b000: loadData = {{24{byteVal[7]}}, byteVal};
        3'b001: begin
          accessErr = lane[0];
          loadData  = {{16{halfVal[15]}}, halfVal};
        end
        3'b010: begin
          accessErr = (lane != 2'd0);
          loadData  = rdWord;
        end
        3'b100: loadData = {24'd0, byteVal};
        3'b101: begin
          accessErr = lane[0];
          loadData  = {16'd0, halfVal};
        end
        default: accessErr = 1'b1;
      endcase
    end
    if (accessErr || accessWrite) begin
      loadData = '0;
    end
  end

  always_comb begin
    newWord = rdWord;
    case (accessFunct3)
      3'b000: begin
        case (lane)
          2'd0:    newWord[7:0]   = accessWdata[7:0];
          2'd1:    newWord[15:8]  = accessWdata[7:0];
          2'd2:    newWord[23:16] = accessWdata[7:0];
          default: newWord[31:24] = accessWdata[7:0];
        endcase
      end
      3'b001: begin
        if (lane[1]) begin
          newWord[31:16] = accessWdata[15:0];
        end else begin
          newWord[15:0] = accessWdata[15:0];
        end
      end
      3'b010:  newWord = accessWdata;
      default: newWord = rdWord;
    endcase
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    captureEn = 1'b0;
    commit    = 1'b0;
    respTaken = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          captureEn = 1'b1;
          countNext = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            stateNext = RESP;
            commit    = 1'b1;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        countNext = count - 4'd1;
        if (count == 4'd1) begin
          stateNext = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          stateNext = IDLE;
          respTaken = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The array write lives here so a held reset also blocks any commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      capWrite  <= 1'b0;
      capFunct3 <= '0;
      capAddr   <= '0;
      capWdata  <= '0;
      respRdata <= '0;
      respErr   <= 1'b0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (captureEn) begin
        capWrite  <= req_write;
        capFunct3 <= req_funct3;
        capAddr   <= req_addr[ADDR_WIDTH-1:0];
        capWdata  <= req_wdata;
      end
      if (commit) begin
        respRdata <= loadData;
        respErr   <= accessErr;
        if (accessWrite && !accessErr) begin
          memArray[wordIdx] <= newWord;
        end
      end else if (respTaken) begin
        respRdata <= '0;
        respErr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) driven with
// directed and random transactions, checked against a byte-level memory model.
module tb_data_mem_responder;

    localparam int AW = 12;
    localparam int NW = 2 ** (AW - 2);

    logic        clk = 1'b0;
    logic        rstN       [2];
    logic        reqValid   [2];
    logic        reqReady   [2];
    logic        reqWrite   [2];
    logic [2:0]  reqFunct3  [2];
    logic [31:0] reqAddr    [2];
    logic [31:0] reqWdata   [2];
    logic        respValid  [2];
    logic        respReady  [2];
    logic [31:0] respRdata  [2];
    logic        respErr    [2];

    int          lat [2] = '{2, 1};
    logic [31:0] modelMem [2][NW];

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(2), .MEM_INIT_FILE("")) dut0 (
        .clk(clk), .rst(rstN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_write(reqWrite[0]), .req_funct3(reqFunct3[0]), .req_addr(reqAddr[0]),
        .req_wdata(reqWdata[0]), .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .resp_rdata(respRdata[0]), .resp_err(respErr[0])
    );

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .LATENCY(1), .MEM_INIT_FILE("")) dut1 (
        .clk(clk), .rst(rstN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_write(reqWrite[1]), .req_funct3(reqFunct3[1]), .req_addr(reqAddr[1]),
        .req_wdata(reqWdata[1]), .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .resp_rdata(respRdata[1]), .resp_err(respErr[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed view of the word array with RISC-V access rules.
    task automatic modelAccess(input int d, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] expData, output logic expErr);
        int unsigned idx;
        int unsigned ln;
        int unsigned size;
        logic [31:0] w;
        logic [31:0] mask;
        idx = (addr % 4096) / 4;
        ln = addr % 4;
        w = modelMem[d][idx];
        expData = 0;
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if (wr) expErr = (f3 > 2);
        else    expErr = (f3 == 3) || (f3 > 5);
        if (!expErr && (ln % size) != 0) expErr = 1'b1;
        if (expErr) return;
        if (wr) begin
            for (int i = 0; i < size; i++) begin
                w = (w & ~(32'hFF << (8 * (ln + i)))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * (ln + i)));
            end
            modelMem[d][idx] = w;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
            expData = (w >> (8 * ln)) & mask;
            if (f3 < 4 && size < 4 && expData[8 * size - 1]) expData = expData | ~mask;
        end
    endtask

    // One full transaction; hold > 0 stalls the response and offers a new request meanwhile.
    task automatic doTxn(input int d, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold, input string tag);
        logic [31:0] expData;
        logic        expErr;
        int          cyc;
        modelAccess(d, wr, f3, addr, wdata, expData, expErr);
        @(negedge clk);
        checkVal({tag, ".ready"}, 32'(reqReady[d]), 32'd1);
        reqValid[d] = 1'b1; reqWrite[d] = wr; reqFunct3[d] = f3;
        reqAddr[d] = addr; reqWdata[d] = wdata;
        @(posedge clk);
        @(negedge clk);
        reqValid[d] = 1'b0; reqWrite[d] = $urandom; reqFunct3[d] = 3'($urandom);
        reqAddr[d] = $urandom; reqWdata[d] = $urandom;
        cyc = 1;
        while (!respValid[d] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkVal({tag, ".lat"}, 32'(cyc), 32'(lat[d]));
        checkVal({tag, ".rdata"}, respRdata[d], expData);
        checkVal({tag, ".err"}, 32'(respErr[d]), 32'(expErr));
        checkVal({tag, ".rdyInResp"}, 32'(reqReady[d]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            reqValid[d] = 1'b1; reqWrite[d] = 1'b0; reqFunct3[d] = 3'b010; reqAddr[d] = 32'h0;
            @(negedge clk);
            checkVal({tag, ".holdValid"}, 32'(respValid[d]), 32'd1);
            checkVal({tag, ".holdRdata"}, respRdata[d], expData);
            checkVal({tag, ".holdErr"}, 32'(respErr[d]), 32'(expErr));
            checkVal({tag, ".holdReady"}, 32'(reqReady[d]), 32'd0);
        end
        respReady[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        respReady[d] = 1'b0;
        reqValid[d] = 1'b0;
        checkVal({tag, ".postValid"}, 32'(respValid[d]), 32'd0);
        checkVal({tag, ".postRdata"}, respRdata[d], 32'd0);
        checkVal({tag, ".postReady"}, 32'(reqReady[d]), 32'd1);
    endtask

    task automatic checkIdleOutputs(input int d, input string tag);
        checkVal({tag, ".ready"}, 32'(reqReady[d]), 32'd1);
        checkVal({tag, ".valid"}, 32'(respValid[d]), 32'd0);
        checkVal({tag, ".rdata"}, respRdata[d], 32'd0);
        checkVal({tag, ".err"}, 32'(respErr[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] dummyData;
        logic        dummyErr;
        for (int d = 0; d < 2; d++) begin
            rstN[d] = 1'b0; reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqFunct3[d] = '0;
            reqAddr[d] = '0; reqWdata[d] = '0; respReady[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkIdleOutputs(0, "rst0");
        checkIdleOutputs(1, "rst1");
        rstN[0] = 1'b1; rstN[1] = 1'b1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) doTxn(d, 1'b1, 3'b010, 32'(i * 4), $urandom, 0, "preload");
        end

        doTxn(0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, "sw100");
        doTxn(0, 1'b0, 3'b010, 32'h100, 32'h0, 0, "lw100");
        doTxn(0, 1'b1, 3'b000, 32'h102, 32'h80, 0, "sb102");
        doTxn(0, 1'b0, 3'b010, 32'h100, 32'h0, 0, "lw100b");
        doTxn(0, 1'b0, 3'b000, 32'h102, 32'h0, 0, "lb102");
        doTxn(0, 1'b0, 3'b100, 32'h102, 32'h0, 0, "lbu102");
        doTxn(0, 1'b0, 3'b101, 32'h102, 32'h0, 0, "lhu102");
        doTxn(0, 1'b1, 3'b001, 32'h101, 32'hFFFF, 0, "shMis");
        doTxn(0, 1'b0, 3'b010, 32'h100, 32'h0, 0, "lw100c");
        doTxn(0, 1'b0, 3'b010, 32'h102, 32'h0, 0, "lwMis");
        doTxn(0, 1'b0, 3'b011, 32'h100, 32'h0, 0, "ldIll");
        doTxn(0, 1'b0, 3'b010, 32'h100, 32'h0, 5, "bpress");

        // Reset while the store is still in WAIT: store must be dropped.
        doTxn(0, 1'b1, 3'b010, 32'h200, 32'h0BADF00D, 0, "sw200");
        @(negedge clk);
        reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqFunct3[0] = 3'b010;
        reqAddr[0] = 32'h200; reqWdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        checkVal("rstWait.pre", 32'(reqReady[0]), 32'd0);
        rstN[0] = 1'b0;
        #1;
        checkIdleOutputs(0, "rstWait");
        @(negedge clk);
        rstN[0] = 1'b1;
        doTxn(0, 1'b0, 3'b010, 32'h200, 32'h0, 0, "lw200a");

        // Reset while in RESP: the store is already committed.
        @(negedge clk);
        reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqFunct3[0] = 3'b010;
        reqAddr[0] = 32'h200; reqWdata[0] = 32'h12345678;
        modelAccess(0, 1'b1, 3'b010, 32'h200, 32'h12345678, dummyData, dummyErr);
        @(posedge clk);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk);
        checkVal("rstResp.pre", 32'(respValid[0]), 32'd1);
        rstN[0] = 1'b0;
        #1;
        checkIdleOutputs(0, "rstResp");
        @(negedge clk);
        rstN[0] = 1'b1;
        doTxn(0, 1'b0, 3'b010, 32'h200, 32'h0, 0, "lw200b");

        doTxn(1, 1'b1, 3'b010, 32'h1004, 32'hA5A5A5A5, 0, "alias.sw");
        doTxn(1, 1'b0, 3'b010, 32'h0004, 32'h0, 0, "alias.lw");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 80; i++) begin
                doTxn(d, 1'($urandom), 3'($urandom),
                      ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                      $urandom, $urandom_range(0, 2), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
